// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the frame-synchronised draw sequencer.
package draw_sched_pkg;

    localparam int DRAW_SCHED_MAX_SLOTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_INIT,
        ST_CLR_DRAW,
        ST_INIT,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } draw_sched_state_t;

    // Slot index width; a single-slot table still needs a 1-bit index.
    function automatic int slot_idx_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/draw_sched_table.sv
// Slot register file: synchronous write port, asynchronous read port, all entries cleared on reset.
// Out-of-range write addresses are dropped so non-power-of-two tables stay consistent.
module draw_sched_table
    import draw_sched_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int SLOTS = 4,
    parameter int CIDXW = 4,
    localparam int SW   = slot_idx_w(SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SW-1:0]    wslot,
    input  logic             wen,
    input  logic [CORDW-1:0] wx,
    input  logic [CORDW-1:0] wy,
    input  logic [CORDW-1:0] ww,
    input  logic [CORDW-1:0] wh,
    input  logic [CIDXW-1:0] wcidx,
    input  logic [SW-1:0]    rslot,
    output logic             ren,
    output logic [CORDW-1:0] rx,
    output logic [CORDW-1:0] ry,
    output logic [CORDW-1:0] rw,
    output logic [CORDW-1:0] rh,
    output logic [CIDXW-1:0] rcidx
);

    logic             en_q   [SLOTS];
    logic [CORDW-1:0] x_q    [SLOTS];
    logic [CORDW-1:0] y_q    [SLOTS];
    logic [CORDW-1:0] w_q    [SLOTS];
    logic [CORDW-1:0] h_q    [SLOTS];
    logic [CIDXW-1:0] cidx_q [SLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                en_q[i]   <= 1'b0;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                w_q[i]    <= '0;
                h_q[i]    <= '0;
                cidx_q[i] <= '0;
            end
        end else if (we && (int'(wslot) < SLOTS)) begin
            en_q[wslot]   <= wen;
            x_q[wslot]    <= wx;
            y_q[wslot]    <= wy;
            w_q[wslot]    <= ww;
            h_q[wslot]    <= wh;
            cidx_q[wslot] <= wcidx;
        end
    end

    // Combinational read: INIT sees the value before any same-cycle write.
    assign ren   = en_q[rslot];
    assign rx    = x_q[rslot];
    assign ry    = y_q[rslot];
    assign rw    = w_q[rslot];
    assign rh    = h_q[rslot];
    assign rcidx = cidx_q[rslot];

endmodule

// File: rtl/draw_sched.sv
// Frame-synchronised sequencer sharing one rectangle-fill engine across a slot table.
// Optional background clear per frame is compiled in with DRAW_SCHED_CLEAR_EN.
module draw_sched
    import draw_sched_pkg::*;
#(
    parameter int CORDW     = 16,
    parameter int SLOTS     = 4,
    parameter int CIDXW     = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int BG_CIDX   = 0,
    localparam int SW       = slot_idx_w(SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_slot,
    input  logic             cfg_en,
    input  logic [CORDW-1:0] cfg_x,
    input  logic [CORDW-1:0] cfg_y,
    input  logic [CORDW-1:0] cfg_w,
    input  logic [CORDW-1:0] cfg_h,
    input  logic [CIDXW-1:0] cfg_cidx,
    input  logic             clr_overrun,
    input  logic             draw_done,
    output logic             draw_start,
    output logic [CORDW-1:0] x0,
    output logic [CORDW-1:0] y0,
    output logic [CORDW-1:0] x1,
    output logic [CORDW-1:0] y1,
    output logic [CIDXW-1:0] cidx,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    draw_sched_state_t state, state_n;
    logic [SW-1:0]     idx, idx_n;
    logic              ld_clr, ld_slot, start_n;

    logic             rd_en;
    logic [CORDW-1:0] rd_x, rd_y, rd_w, rd_h;
    logic [CIDXW-1:0] rd_cidx;

    draw_sched_table #(
        .CORDW (CORDW),
        .SLOTS (SLOTS),
        .CIDXW (CIDXW)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we),
        .wslot (cfg_slot),
        .wen   (cfg_en),
        .wx    (cfg_x),
        .wy    (cfg_y),
        .ww    (cfg_w),
        .wh    (cfg_h),
        .wcidx (cfg_cidx),
        .rslot (idx),
        .ren   (rd_en),
        .rx    (rd_x),
        .ry    (rd_y),
        .rw    (rd_w),
        .rh    (rd_h),
        .rcidx (rd_cidx)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        ld_clr  = 1'b0;
        ld_slot = 1'b0;
        start_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idx_n = '0;
                if (frame) begin
`ifdef DRAW_SCHED_CLEAR_EN
                    state_n = ST_CLR_INIT;
`else
                    state_n = ST_INIT;
`endif
                end
            end
`ifdef DRAW_SCHED_CLEAR_EN
            ST_CLR_INIT: begin
                ld_clr  = 1'b1;
                start_n = 1'b1;
                state_n = ST_CLR_DRAW;
            end
            ST_CLR_DRAW: begin
                if (draw_done) state_n = ST_INIT;
            end
`endif
            ST_INIT: begin
                // Disabled or degenerate slots cost only INIT+NEXT, no engine job.
                if (rd_en && (rd_w != '0) && (rd_h != '0)) begin
                    ld_slot = 1'b1;
                    start_n = 1'b1;
                    state_n = ST_DRAW;
                end else begin
                    state_n = ST_NEXT;
                end
            end
            ST_DRAW: begin
                if (draw_done) state_n = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx == SW'(SLOTS - 1)) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = ST_INIT;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            cidx       <= '0;
            draw_start <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            draw_start <= start_n;
            frame_done <= (state_n == ST_DONE);
            if (ld_clr) begin
                x0   <= '0;
                y0   <= '0;
                x1   <= CORDW'(FB_WIDTH - 1);
                y1   <= CORDW'(FB_HEIGHT - 1);
                cidx <= CIDXW'(BG_CIDX);
            end else if (ld_slot) begin
                x0   <= rd_x;
                y0   <= rd_y;
                x1   <= rd_x + rd_w - 1'b1;
                y1   <= rd_y + rd_h - 1'b1;
                cidx <= rd_cidx;
            end
            // Set has priority over clear so a coincident overrun is never lost.
            if (frame && (state != ST_IDLE)) overrun <= 1'b1;
            else if (clr_overrun)            overrun <= 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
